// File: rtl/dither_rle_encoder.sv
// dither_rle_encoder: 1-bit raster run-length encoder feeding a first-word-fall-through token FIFO.
// Define RLE_ROW_BREAK_EN to also end every run at the last column of each row.
module dither_rle_encoder #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int MAX_RUN    = 255,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pixel_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    output logic        token_value_out,
    output logic [7:0]  token_len_out,
    output logic        token_sof_out,
    output logic        token_eof_out,
    output logic        token_valid_out,
    input  logic        token_ready_in,
    output logic        overflow_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef struct packed {
        logic       val;
        logic [7:0] len;
        logic       sof;
        logic       eof;
    } tok_t;
    tok_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d, free;
    logic          active_q, val_q, sof_q, ovf_q;
    logic [7:0]    len_q, upd_len;
    logic          pix_ok, fs, fe, row_end, close_a, close_b, restart, pop, upd_val, upd_sof;
    logic [1:0]    n_req, n_wr;
    tok_t          tok_a, tok_b, tok0, head;
    always_comb begin
        pix_ok  = valid_in && hcount_in < 11'(WIDTH) && vcount_in < 10'(HEIGHT);
        fs      = hcount_in == 11'd0 && vcount_in == 10'd0;
        fe      = hcount_in == 11'(WIDTH - 1) && vcount_in == 10'(HEIGHT - 1);
`ifdef RLE_ROW_BREAK_EN
        row_end = hcount_in == 11'(WIDTH - 1);
`else
        row_end = 1'b0;
`endif
        close_a = pix_ok && active_q && (fs || pixel_in != val_q || len_q == 8'(MAX_RUN));
        restart = !active_q || close_a;
        upd_val = restart ? pixel_in : val_q;
        upd_len = restart ? 8'd1 : len_q + 8'd1;
        upd_sof = restart ? fs : sof_q;
        close_b = pix_ok && (fe || row_end);
        tok_a   = {val_q, len_q, sof_q, 1'b0};
        tok_b   = {upd_val, upd_len, upd_sof, fe};
        tok0    = close_a ? tok_a : tok_b;
        n_req   = {1'b0, close_a} + {1'b0, close_b};
        pop     = count_q != '0 && token_ready_in;
        // Space freed by this cycle's pop is reusable by this cycle's pushes.
        free    = CW'(FIFO_DEPTH) - count_q + CW'(pop);
        n_wr    = free >= CW'(n_req) ? n_req : free[1:0];
        count_d = count_q - CW'(pop) + CW'(n_wr);
        head    = mem_q[rd_q];
    end
    assign token_valid_out = count_q != '0;
    assign {token_value_out, token_len_out, token_sof_out, token_eof_out} = token_valid_out ? head : '0;
    assign overflow_out = ovf_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_q <= 1'b0;
            val_q    <= 1'b0;
            len_q    <= 8'd0;
            sof_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
        end else begin
            if (pix_ok) begin
                active_q <= !close_b;
                val_q    <= upd_val;
                len_q    <= upd_len;
                sof_q    <= upd_sof;
            end
            rd_q    <= rd_q + PW'(pop);
            wr_q    <= wr_q + PW'(n_wr);
            count_q <= count_d;
            ovf_q   <= ovf_q || n_wr != n_req;
        end
    end
    always_ff @(posedge clk_in) begin
        if (n_wr != 2'd0) mem_q[wr_q] <= tok0;
        if (n_wr == 2'd2) mem_q[wr_q + PW'(1)] <= tok_b;
    end
endmodule

// File: tb/tb_dither_rle_encoder.sv
// tb_dither_rle_encoder: directed and randomized checks against a queue-based run/FIFO model.
module tb_dither_rle_encoder;
    localparam int W = 64, H = 6, MAX = 50, D = 8;
`ifdef RLE_ROW_BREAK_EN
    localparam bit ROWBRK = 1'b1;
`else
    localparam bit ROWBRK = 1'b0;
`endif
    logic        clk_in = 0, rst_in = 1, pixel_in = 0, valid_in = 0, token_ready_in = 1;
    logic [10:0] hcount_in = 0;
    logic [9:0]  vcount_in = 0;
    logic        token_value_out, token_sof_out, token_eof_out, token_valid_out, overflow_out;
    logic [7:0]  token_len_out;
    int          checks = 0, errors = 0;
    logic [10:0] mq[$], mlog[$], dut_log[$];
    logic        m_ovf = 0, rv = 0, rs = 0;
    bit          ra = 0;
    int          rl = 0;

    dither_rle_encoder #(.WIDTH(W), .HEIGHT(H), .MAX_RUN(MAX), .FIFO_DEPTH(D)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .pixel_in(pixel_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .valid_in(valid_in), .token_value_out(token_value_out),
        .token_len_out(token_len_out), .token_sof_out(token_sof_out), .token_eof_out(token_eof_out),
        .token_valid_out(token_valid_out), .token_ready_in(token_ready_in), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [10:0] tk(input logic v, input int l, input logic s, input logic e);
        return {v, 8'(l), s, e};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic pin(input string n, input int i, input logic [31:0] e);
        chk({n, "_dut"}, i < dut_log.size() ? 32'(dut_log[i]) : 32'hdead, e);
        chk({n, "_model"}, i < mlog.size() ? 32'(mlog[i]) : 32'hdead, e);
    endtask

    // Reference: runs from the rules, FIFO as a bounded queue with pop before push.
    always @(posedge clk_in) begin
        logic [10:0] toks[2];
        int          nt;
        logic        fs, fe;
        if (rst_in) begin
            mq.delete();
            m_ovf = 0;
            ra = 0;
        end else begin
            if (mq.size() != 0 && token_ready_in) mlog.push_back(mq.pop_front());
            if (valid_in && hcount_in < W && vcount_in < H) begin
                fs = hcount_in == 0 && vcount_in == 0;
                fe = hcount_in == W - 1 && vcount_in == H - 1;
                nt = 0;
                if (ra && (fs || pixel_in != rv || rl == MAX)) begin
                    toks[nt] = tk(rv, rl, rs, 0);
                    nt++;
                    ra = 0;
                end
                if (!ra) begin
                    rv = pixel_in;
                    rl = 0;
                    rs = fs;
                    ra = 1;
                end
                rl++;
                if (fe || (ROWBRK && hcount_in == W - 1)) begin
                    toks[nt] = tk(rv, rl, rs, fe);
                    nt++;
                    ra = 0;
                end
                for (int i = 0; i < nt; i++)
                    if (mq.size() < D) mq.push_back(toks[i]);
                    else m_ovf = 1;
            end
        end
    end

    always @(negedge clk_in) begin
        logic [10:0] head;
        head = {token_value_out, token_len_out, token_sof_out, token_eof_out};
        chk("valid", token_valid_out, mq.size() != 0);
        if (mq.size() != 0) chk("head", head, mq[0]);
        chk("overflow", overflow_out, m_ovf);
        if (token_valid_out && token_ready_in) dut_log.push_back(head);
    end

    task automatic px(input logic p, input int h, input int v);
        pixel_in = p;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        valid_in = 1;
        @(posedge clk_in); #1;
        valid_in = 0;
    endtask

    task automatic idle(input int n);
        valid_in = 0;
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic do_reset();
        rst_in = 1;
        @(posedge clk_in); #1;
        rst_in = 0;
        mlog.delete();
        dut_log.delete();
    endtask

    initial begin
        int   h, v, r;
        logic p;
        @(posedge clk_in); #1;
        chk("rst_valid", token_valid_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_tok", {token_value_out, token_len_out, token_sof_out, token_eof_out}, 0);
        do_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) px(1, x, y);
        idle(12);
        chk("white_n", dut_log.size(), ROWBRK ? 12 : 8);
        chk("white_n_model", mlog.size(), ROWBRK ? 12 : 8);
        pin("white_first", 0, tk(1, 50, 1, 0));
        pin("white_second", 1, ROWBRK ? tk(1, 14, 0, 0) : tk(1, 50, 0, 0));
        pin("white_last", ROWBRK ? 11 : 7, tk(1, ROWBRK ? 14 : 34, 0, 1));
        chk("white_ovf", overflow_out, 0);
        do_reset();
        for (int x = 0; x < W; x++) px(1'(x & 1), x, 0);
        idle(12);
        chk("alt_n", dut_log.size(), ROWBRK ? 64 : 63);
        for (int i = 0; i < 63; i++) pin($sformatf("alt%0d", i), i, tk(1'(i & 1), 1, i == 0, 0));
        do_reset();
        for (int x = 0; x < W; x++) px(x == W - 1, x, 0);
        idle(12);
        chk("blk_n", dut_log.size(), ROWBRK ? 3 : 2);
        pin("blk0", 0, tk(0, 50, 1, 0));
        pin("blk1", 1, tk(0, 13, 0, 0));
        pin("blk2", 2, ROWBRK ? 32'(tk(1, 1, 0, 0)) : 32'hdead);
        do_reset();
        token_ready_in = 0;
        for (int x = 0; x < 20; x++) px(1'(x & 1), x, 0);
        idle(2);
        chk("ovf_valid", token_valid_out, 1);
        chk("ovf_flag", overflow_out, 1);
        token_ready_in = 1;
        idle(12);
        chk("ovf_drained", dut_log.size(), D);
        for (int i = 0; i < D; i++) pin($sformatf("ovf_order%0d", i), i, tk(1'(i & 1), 1, i == 0, 0));
        chk("ovf_sticky", overflow_out, 1);
        token_ready_in = 0;
        px(0, 20, 0);
        px(1, 21, 0);
        px(0, 22, 0);
        chk("q3_valid", token_valid_out, 1);
        chk("q3_ovf", overflow_out, 1);
        do_reset();
        chk("rstmid_valid", token_valid_out, 0);
        chk("rstmid_ovf", overflow_out, 0);
        token_ready_in = 1;
        px(1, 14, 2);
        px(1, 15, 2);
        px(0, 0, 0);
        px(1, 1, 0);
        idle(6);
        pin("pre_frame", 0, tk(1, 2, 0, 0));
        pin("new_frame", 1, tk(0, 1, 1, 0));
        do_reset();
        h = 0;
        v = 0;
        p = 0;
        for (int c = 0; c < 2000; c++) begin
            token_ready_in = (c >= 1200 && c < 1300) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            rst_in = (c == 800);
            valid_in = 0;
            if ($urandom_range(0, 9) >= 3) begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    pixel_in = 1'($urandom);
                    hcount_in = 11'(r == 0 ? W + $urandom_range(0, 1983) : $urandom_range(0, W - 1));
                    vcount_in = 10'(r == 0 ? $urandom_range(0, H - 1) : H + $urandom_range(0, 1017));
                end else begin
                    if ($urandom_range(0, 999) == 0) begin h = 0; v = 0; end
                    if ($urandom_range(0, 99) < (((c / 250) % 2) != 0 ? 2 : 35)) p = ~p;
                    pixel_in = p;
                    hcount_in = 11'(h);
                    vcount_in = 10'(v);
                    h++;
                    if (h == W) begin h = 0; v = (v + 1) % H; end
                end
                valid_in = 1;
            end
            @(posedge clk_in); #1;
        end
        rst_in = 0;
        token_ready_in = 1;
        idle(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dither_rle_encoder.md
# dither_rle_encoder

Run-length encoder for the 1-bit dithered camera stream. Sits directly downstream of the dither stage, in parallel with the 1-bit dithered frame buffer write port. It consumes the raster-ordered (pixel, hcount, vcount, valid) stream and emits (value, length, sof, eof) run tokens through a FIFO with a valid/ready handshake. These tokens feed the image-compression/export path.

## Interface
- WIDTH, 320: pixels per row of the camera image.
- HEIGHT, 240: rows per frame.
- MAX_RUN, 255: longest run per token; must be ≤ 255 (8-bit length field).
- FIFO_DEPTH, 16: token FIFO entries; power of two, ≥ 4.
- clk_in  input  1  pixel clock (74.25 MHz); one clock; reset is synchronous and active-high.
- rst_in  input  1  synchronous, active-high reset.
- pixel_in  input  1  dithered pixel (1 = white).
- hcount_in  input  11  column of pixel_in, 0..WIDTH-1.
- vcount_in  input  10  row of pixel_in, 0..HEIGHT-1.
- valid_in  input  1  single-cycle pixel strobe; no backpressure; may be high on consecutive cycles.
- token_value_out  output  1  pixel value of the run.
- token_len_out  output  8  run length, 1..MAX_RUN (actual count, not minus one).
- token_sof_out  output  1  first token of a frame.
- token_eof_out  output  1  last token of a frame.
- token_valid_out  output  1  FIFO non-empty.
- token_ready_in  input  1  consumer accepts the head token when valid & ready.
- overflow_out  output  1  sticky: at least one token was dropped.

## Operation
- Run state: active flag, cur_val, cur_len (8 b), cur_sof.
- On each cycle with valid_in, evaluate in order:
  - Frame start (hcount_in==0 && vcount_in==0). If a run is active, close it with eof=0, because the frame was cut short. The new run then gets sof=1.
  - If no run is active, start a run of (pixel_in, 1).
  - If pixel_in != cur_val, or cur_len == MAX_RUN, close the current run and start a run of (pixel_in, 1).
  - Otherwise, cur_len+1.
  - If the pixel is the last of the frame (hcount_in==WIDTH-1 && vcount_in==HEIGHT-1), close the updated run with eof=1 and clear the active flag.
  - Row-end closing is controlled by the macro; see Configuration.
- Up to two tokens can close in one cycle: the old run plus a length-1 run ending at a row or frame boundary. The FIFO accepts 0, 1 or 2 writes per cycle, in stream order.
- sof=1 only on the first token closed after a frame-start pixel. eof=1 only on the frame-end token.
- FIFO is first-word-fall-through, and the outputs drive the head entry directly. The head pops on token_valid_out && token_ready_in. A pop and 1–2 pushes in the same cycle are all legal.
- Full: free space is computed after the same-cycle pop.
  - If fewer free slots remain than required, drop the tokens that do not fit; the earlier token is kept if one fits.
  - Set overflow_out. The run state still advances normally.
- Pixels with out-of-range coordinates (hcount_in ≥ WIDTH or vcount_in ≥ HEIGHT) are ignored completely.

## Timing
- Reset values:
  - all outputs 0; token_valid_out=0, overflow_out=0.
  - FIFO empty, no run active.
- A reset mid-run discards the partial run and all FIFO contents. The next token emitted requires a fresh frame-start pixel to carry sof=1; tokens before that carry sof=0.
- Latency: a token closed by the pixel sampled on edge E is written on edge E. It is visible on the outputs from E+1 if the FIFO was empty.
- token_ready_in is sampled on the clock edge; outputs change only after edges.
- overflow_out stays high until rst_in.
- FIFO count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Configuration
- RLE_ROW_BREAK_EN defined:
  - a pixel with hcount_in==WIDTH-1 also closes the updated run (eof=0, unless it is the frame end) and clears the active flag.
  - Runs never span rows.
- Undefined: runs continue across row boundaries. Only a value change, MAX_RUN, frame start and frame end terminate a run.

## Test plan
- RLE_ROW_BREAK_EN, all-white 320×240 frame, valid every cycle, ready=1:
  - 480 tokens, alternating (1,255),(1,65);
  - first token sof=1, last token eof=1, no overflow.
- Macro undefined, same frame:
  - 302 tokens: 301×(1,255) then (1,45) with eof=1.
- Row of alternating 0/1 pixels:
  - 320 tokens, each length 1, values alternating starting 0.
- RLE_ROW_BREAK_EN, row of 319 black then 1 white, back-to-back valid:
  - tokens (0,255), (0,64), (1,1);
  - the last two are written on the same edge and read out in that order.
- token_ready_in=0, FIFO_DEPTH=16, 40 alternating pixels:
  - exactly 16 tokens are held and overflow_out=1 persists;
  - after ready rises, the first 16 tokens drain in order.
- rst_in pulsed mid-row with 3 tokens queued:
  - next cycle token_valid_out=0 and overflow_out=0;
  - the following frame's first token has sof=1.
